// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/ERET sequencer and Cp0.
//  - FSM state encoding (IDLE, DRAIN, COMMIT, FLUSH)
//  - default cause codes for syscall / break / teq
//  - Cp0 status bit indices (IE plus per-trap enables)
//  - EXCEPTION_ADDR, the handler entry point Cp0 returns on epc_out
//  - eret_target(): address fetch resumes at after an eret
package exc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

   localparam logic [4:0] CAUSE_SYSCALL_DEF = 5'd8;
   localparam logic [4:0] CAUSE_BREAK_DEF   = 5'd9;
   localparam logic [4:0] CAUSE_TEQ_DEF     = 5'd13;

   localparam int STATUS_IE      = 0;
   localparam int STATUS_SYSCALL = 1;
   localparam int STATUS_BREAK   = 2;
   localparam int STATUS_TEQ     = 3;

   localparam logic [31:0] EXCEPTION_ADDR = 32'h8000_0180;

   // Resume after the instruction that raised the exception; the add is
   // 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
   function automatic logic [31:0] eret_target(input logic [31:0] epc);
      return epc + 32'd4;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational request selection for exc_ctrl.
// Picks the highest-priority request (eret > syscall > break > teq) and
// only then applies the status mask, so a masked high-priority trap drops
// every lower-priority request raised alongside it.
// Ports:
//  id_valid, id_stall          ID qualifiers; nothing is taken while stalled
//  id_syscall/id_break/id_teq/id_eret  decoded requests
//  status_en[3:0]              Cp0 status: IE and per-trap enables
//  take                        a request is accepted this cycle
//  is_eret                     accepted request is eret (else an exception)
//  cause                       cause code of the selected request (0 for eret)
module exc_prio_enc
   import exc_ctrl_pkg::*;
#(
   parameter logic [4:0] CAUSE_SYSCALL = CAUSE_SYSCALL_DEF,
   parameter logic [4:0] CAUSE_BREAK   = CAUSE_BREAK_DEF,
   parameter logic [4:0] CAUSE_TEQ     = CAUSE_TEQ_DEF
)(
   input  logic       id_valid,
   input  logic       id_stall,
   input  logic       id_syscall,
   input  logic       id_break,
   input  logic       id_teq,
   input  logic       id_eret,
   input  logic [3:0] status_en,
   output logic       take,
   output logic       is_eret,
   output logic [4:0] cause
);

   always_comb begin
      take    = 1'b0;
      is_eret = 1'b0;
      cause   = 5'd0;
      if (id_valid && !id_stall) begin
         if (id_eret) begin
            // eret is never masked
            take    = 1'b1;
            is_eret = 1'b1;
         end else if (id_syscall) begin
            take  = status_en[STATUS_IE] & status_en[STATUS_SYSCALL];
            cause = CAUSE_SYSCALL;
         end else if (id_break) begin
            take  = status_en[STATUS_IE] & status_en[STATUS_BREAK];
            cause = CAUSE_BREAK;
         end else if (id_teq) begin
            take  = status_en[STATUS_IE] & status_en[STATUS_TEQ];
            cause = CAUSE_TEQ;
         end
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / ERET sequencer sitting in front of Cp0.
// Accepts syscall/break/teq/eret from ID (gated by Cp0 status), waits for
// the mult/div unit to drain, pulses exception or eret into Cp0 for one
// cycle, then flushes the pipeline and redirects fetch to the address Cp0
// presents on epc_out.
// Ports:
//  clk, rst          clock; asynchronous active-high reset
//  id_*              ID-stage instruction, PC and decoded requests
//  status            Cp0 status (bit0 IE, bit1 syscall, bit2 break, bit3 teq)
//  epc_out           Cp0 target: EPC while eret is high, else handler address
//  md_busy           mult/div unit busy
//  exception, eret   one-cycle pulses to Cp0 (mutually exclusive)
//  cause, exc_pc     cause code / faulting PC, valid with the pulse
//  flush             squash IF/ID/EX for FLUSH_CYCLES cycles
//  freeze            hold PC and IF/ID whenever the FSM is not IDLE
//  redirect          one-cycle pulse: load PC from redirect_pc
//  redirect_pc       fetch target, held until the next commit
//  state_dbg         current FSM state (state_t encoding)
//
// Request semantics: a request is consumed on the clock edge where the FSM
// is IDLE and id_valid & ~id_stall & request hold; there is no back-pressure
// signal, so anything presented while the FSM is busy is simply dropped.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int         FLUSH_CYCLES  = 2,
   parameter logic [4:0] CAUSE_SYSCALL = CAUSE_SYSCALL_DEF,
   parameter logic [4:0] CAUSE_BREAK   = CAUSE_BREAK_DEF,
   parameter logic [4:0] CAUSE_TEQ     = CAUSE_TEQ_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_stall,
   input  logic [31:0] id_pc,
   input  logic        id_syscall,
   input  logic        id_break,
   input  logic        id_teq,
   input  logic        id_eret,
   input  logic [31:0] status,
   input  logic [31:0] epc_out,
   input  logic        md_busy,
   output logic        exception,
   output logic        eret,
   output logic [4:0]  cause,
   output logic [31:0] exc_pc,
   output logic        flush,
   output logic        freeze,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [1:0]  state_dbg
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t      state;
   logic        kind_eret_q;
   logic [4:0]  cause_q;
   logic [31:0] pc_q;
   logic [3:0]  flush_cnt;

   logic        take;
   logic        take_eret;
   logic [4:0]  take_cause;

   // Only the low status nibble carries enables.
   logic        status_unused;
   assign status_unused = ^status[31:4];

   assign state_dbg = state;

   exc_prio_enc #(
      .CAUSE_SYSCALL (CAUSE_SYSCALL),
      .CAUSE_BREAK   (CAUSE_BREAK),
      .CAUSE_TEQ     (CAUSE_TEQ)
   ) u_prio (
      .id_valid   (id_valid),
      .id_stall   (id_stall),
      .id_syscall (id_syscall),
      .id_break   (id_break),
      .id_teq     (id_teq),
      .id_eret    (id_eret),
      .status_en  (status[3:0]),
      .take       (take),
      .is_eret    (take_eret),
      .cause      (take_cause)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         kind_eret_q <= 1'b0;
         cause_q     <= 5'd0;
         pc_q        <= 32'd0;
         flush_cnt   <= 4'd0;
         exception   <= 1'b0;
         eret        <= 1'b0;
         cause       <= 5'd0;
         exc_pc      <= 32'd0;
         flush       <= 1'b0;
         freeze      <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  kind_eret_q <= take_eret;
                  cause_q     <= take_cause;
                  pc_q        <= id_pc;
                  freeze      <= 1'b1;
                  if (md_busy) begin
                     state <= ST_DRAIN;
                  end else begin
                     // Pulse is registered so it lines up with the COMMIT cycle.
                     state     <= ST_COMMIT;
                     exception <= ~take_eret;
                     eret      <= take_eret;
                     cause     <= take_cause;
                     exc_pc    <= id_pc;
                  end
               end
            end

            ST_DRAIN: begin
               // status is not re-checked here: the mask applied at accept stands.
               if (!md_busy) begin
                  state     <= ST_COMMIT;
                  exception <= ~kind_eret_q;
                  eret      <= kind_eret_q;
                  cause     <= cause_q;
                  exc_pc    <= pc_q;
               end
            end

            ST_COMMIT: begin
               // Cp0 drives epc_out from the pulse it sees this cycle, so the
               // target is captured at the end of COMMIT.
               state       <= ST_FLUSH;
               exception   <= 1'b0;
               eret        <= 1'b0;
               cause       <= 5'd0;
               exc_pc      <= 32'd0;
               flush       <= 1'b1;
               redirect    <= 1'b1;
               redirect_pc <= kind_eret_q ? eret_target(epc_out) : epc_out;
               flush_cnt   <= FLUSH_LOAD;
            end

            ST_FLUSH: begin
               redirect <= 1'b0;
               if (flush_cnt <= 4'd1) begin
                  state     <= ST_IDLE;
                  flush     <= 1'b0;
                  freeze    <= 1'b0;
                  flush_cnt <= 4'd0;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

   localparam int FLUSH_N = 2;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic        id_stall;
   logic [31:0] id_pc;
   logic        id_syscall;
   logic        id_break;
   logic        id_teq;
   logic        id_eret;
   logic [31:0] status;
   logic [31:0] epc_out;
   logic        md_busy;
   logic        exception;
   logic        eret;
   logic [4:0]  cause;
   logic [31:0] exc_pc;
   logic        flush;
   logic        freeze;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   // {eret, exception, cause, exc_pc}
   logic [38:0] exp_q[$];
   logic [31:0] redir_q[$];

   exc_ctrl #(.FLUSH_CYCLES(FLUSH_N)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_stall    (id_stall),
      .id_pc       (id_pc),
      .id_syscall  (id_syscall),
      .id_break    (id_break),
      .id_teq      (id_teq),
      .id_eret     (id_eret),
      .status      (status),
      .epc_out     (epc_out),
      .md_busy     (md_busy),
      .exception   (exception),
      .eret        (eret),
      .cause       (cause),
      .exc_pc      (exc_pc),
      .flush       (flush),
      .freeze      (freeze),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: {take, eret, exception, cause[4:0], pc[31:0]}
   function automatic logic [39:0] model(input logic st, sy, br, tq, er,
                                         input logic [31:0] stat, input logic [31:0] pc);
      logic t, e;
      logic [4:0] c;
      t = 1'b0; e = 1'b0; c = 5'd0;
      if (!st) begin
         if (er) begin t = 1'b1; e = 1'b1; end
         else if (sy) begin t = stat[0] & stat[1]; c = 5'd8;  end
         else if (br) begin t = stat[0] & stat[2]; c = 5'd9;  end
         else if (tq) begin t = stat[0] & stat[3]; c = 5'd13; end
      end
      return {t, e, ~e, c, pc};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (exception || eret) begin
            check_val("pulse_mutex", 64'(exception & eret), 64'd0);
            check_val("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
               check_val("commit_fields", 64'({eret, exception, cause, exc_pc}), 64'(exp_q.pop_front()));
         end
         if (redirect) begin
            check_val("redirect_expected", 64'(redir_q.size() > 0), 64'd1);
            if (redir_q.size() > 0)
               check_val("redirect_pc", 64'(redirect_pc), 64'(redir_q.pop_front()));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic clear_req();
      id_valid = 1'b0; id_stall = 1'b0;
      id_syscall = 1'b0; id_break = 1'b0; id_teq = 1'b0; id_eret = 1'b0;
   endtask

   task automatic do_req(input string name, input logic [31:0] pc,
                         input logic sy, input logic br, input logic tq, input logic er,
                         input logic st, input logic [3:0] stat_nib,
                         input logic [31:0] epc, input int busy, input logic inject);
      logic [39:0] m;
      int n, drain_n, flush_n, freeze_n, redir_n, pulse_at;
      logic injected;
      m = model(st, sy, br, tq, er, {28'd0, stat_nib}, pc);
      @(negedge clk);
      id_valid = 1'b1; id_stall = st; id_pc = pc;
      id_syscall = sy; id_break = br; id_teq = tq; id_eret = er;
      status = {28'd0, stat_nib}; epc_out = epc; md_busy = (busy > 0);
      if (m[39]) begin
         exp_q.push_back(m[38:0]);
         redir_q.push_back(m[38] ? epc + 32'd4 : epc);
      end
      @(negedge clk);
      clear_req();
      n = 0; drain_n = 0; flush_n = 0; freeze_n = 0; redir_n = 0; pulse_at = -1;
      injected = 1'b0;
      while (n < 100) begin
         md_busy = (n + 1 < busy);
         if (!freeze) break;
         freeze_n++;
         if (state_dbg == S_DRAIN) drain_n++;
         if (flush) flush_n++;
         if (redirect) redir_n++;
         if (exception || eret) pulse_at = n;
         if (inject && flush && !injected) begin
            id_valid = 1'b1; id_syscall = 1'b1; status = 32'hF;
            injected = 1'b1;
         end else begin
            clear_req();
         end
         @(negedge clk);
         n++;
      end
      clear_req();
      md_busy = 1'b0;
      check_val({name, "_done_in_time"}, 64'(n < 100), 64'd1);
      check_val({name, "_freeze_cycles"}, 64'(freeze_n), 64'(m[39] ? busy + 1 + FLUSH_N : 0));
      check_val({name, "_drain_cycles"}, 64'(drain_n), 64'(m[39] ? busy : 0));
      check_val({name, "_flush_cycles"}, 64'(flush_n), 64'(m[39] ? FLUSH_N : 0));
      check_val({name, "_redirect_pulses"}, 64'(redir_n), 64'(m[39] ? 1 : 0));
      check_val({name, "_pulse_cycle"}, 64'(pulse_at), 64'(m[39] ? busy : -1));
      check_val({name, "_idle_after"}, 64'(state_dbg), 64'(S_IDLE));
      check_val({name, "_sb_empty"}, 64'(exp_q.size() + redir_q.size()), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      clear_req();
      id_pc = 32'd0; status = 32'd0; epc_out = 32'd0; md_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_ctrl_outs", 64'({exception, eret, cause, flush, freeze, redirect, state_dbg}), 64'd0);
      check_val("reset_addr_outs", 64'({exc_pc, redirect_pc}), 64'd0);
      rst = 1'b0;

      do_req("syscall",      32'h0040_0010, 1, 0, 0, 0, 0, 4'hF, 32'h0040_0004, 0, 0);
      do_req("break_masked", 32'h0040_0020, 0, 1, 0, 0, 0, 4'hB, 32'h8000_0180, 0, 0);
      do_req("teq_drain",    32'h0040_0030, 0, 0, 1, 0, 0, 4'hF, 32'h8000_0180, 5, 0);
      do_req("eret",         32'h0040_0040, 0, 0, 0, 1, 0, 4'h0, 32'h0040_0010, 0, 0);
      do_req("sys_teq_inj",  32'h0040_0050, 1, 0, 1, 0, 0, 4'hF, 32'h8000_0180, 0, 1);
      do_req("stalled",      32'h0040_0060, 1, 0, 0, 0, 1, 4'hF, 32'h8000_0180, 0, 0);
      do_req("eret_wrap",    32'h0040_0070, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFC, 0, 0);
      do_req("ie_clear",     32'h0040_0080, 1, 1, 1, 0, 0, 4'hE, 32'h8000_0180, 0, 0);
      do_req("break_busy",   32'h0040_0090, 0, 1, 0, 0, 0, 4'h5, 32'h8000_0180, 2, 0);

      // Reset in the middle of DRAIN aborts the sequence with no pulse.
      @(negedge clk);
      id_valid = 1'b1; id_teq = 1'b1; id_pc = 32'h0040_00A0;
      status = 32'hF; md_busy = 1'b1; epc_out = 32'h8000_0180;
      @(negedge clk);
      clear_req();
      status = 32'h0;
      @(negedge clk);
      check_val("drain_before_rst", 64'({state_dbg, freeze}), 64'({S_DRAIN, 1'b1}));
      #2 rst = 1'b1;
      #1;
      check_val("rst_abort_ctrl", 64'({exception, eret, cause, flush, freeze, redirect, state_dbg}), 64'd0);
      check_val("rst_abort_addr", 64'({exc_pc, redirect_pc}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      md_busy = 1'b0;
      do_req("after_rst", 32'h0040_00B0, 1, 0, 0, 0, 0, 4'h3, 32'h8000_0180, 0, 0);

      for (int i = 0; i < 6; i++) begin
         do_req("random", $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, 4'($urandom_range(0, 15)),
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
